// File: rtl/mux81_rr_arbiter.sv
// mux81_rr_arbiter: round-robin arbiter sharing one MUX81 (8:1, 1-bit) among
// eight requesters. Emits a registered one-hot grant and the 3-bit mux select.
// An owner keeps the grant while it requests. A hold limit forces rotation
// when another requester is waiting. Between owners there is one SWITCH cycle
// followed by an IDLE arbitration cycle, so the mux output never switches
// mid-transfer.
module mux81_rr_arbiter #(
    parameter int MAX_HOLD = 16,  // 0 = unlimited, legal 0..255
    parameter int CNT_W    = 8    // 2**CNT_W must exceed MAX_HOLD
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] SEL,
    output logic       BUSY,
    output logic       EXPIRED
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Last value the hold counter may reach. With an unlimited hold it
    // collapses to zero, which keeps the counter frozen.
    localparam logic             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q,    state_d;
    logic [7:0]       gnt_q,      gnt_d;
    logic [2:0]       sel_q,      sel_d;
    logic             busy_q,     busy_d;
    logic             expired_q,  expired_d;
    logic [2:0]       ptr_q,      ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic       owner_req;
    logic       others_pending;
    logic       hold_reached;
    logic [2:0] winner;
    logic [2:0] next_ptr;

    // First requester found scanning ptr, ptr+1, ... with wrap modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Helper terms for the grant decision; the owner is always the current SEL.
    always_comb begin
        owner_req      = REQ[sel_q];
        others_pending = |(REQ & ~gnt_q);
        hold_reached   = HOLD_EN && (hold_cnt_q == HOLD_LAST);
        winner         = rr_pick(REQ, ptr_q);
        next_ptr       = sel_q + 3'd1;
    end

    // Next-state and next-output computation for the IDLE/GRANT/SWITCH machine.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        expired_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 8'd1 << winner;
                    sel_d      = winner;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end

            ST_GRANT: begin
                if (!owner_req) begin
                    // Owner dropped: this takes priority over an expiry on the same edge.
                    state_d = ST_SWITCH;
                    gnt_d   = 8'h00;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr;
                end else if (hold_reached && others_pending) begin
                    state_d   = ST_SWITCH;
                    gnt_d     = 8'h00;
                    busy_d    = 1'b0;
                    expired_d = 1'b1;
                    ptr_d     = next_ptr;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            ST_SWITCH: begin
                // Dead cycle. REQ is ignored and SEL stays on the previous owner.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'h00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; the asynchronous reset clears everything at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 8'h00;
            sel_q      <= 3'd0;
            busy_q     <= 1'b0;
            expired_q  <= 1'b0;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            expired_q  <= expired_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign GNT     = gnt_q;
    assign SEL     = sel_q;
    assign BUSY    = busy_q;
    assign EXPIRED = expired_q;

`ifndef SYNTHESIS
    // Output invariants: one-hot grant, grant matches BUSY and SEL, and no back-to-back expiry.
    a_onehot: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(gnt_q));
    a_busy:   assert property (@(posedge CLK) disable iff (!RST_N) ((gnt_q != 8'h00) == busy_q));
    a_sel:    assert property (@(posedge CLK) disable iff (!RST_N)
                               (gnt_q != 8'h00) |-> (gnt_q == (8'd1 << sel_q)));
    a_exp:    assert property (@(posedge CLK) disable iff (!RST_N) expired_q |=> !expired_q);
`endif

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Bench for mux81_rr_arbiter. Directed scenarios plus random REQ traffic are
// compared every cycle against a behavioural model. The model tracks the
// owner, the number of grant cycles and a pending-switch flag.
module tb_mux81_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] REQ;
    logic [7:0] GNT;
    logic [2:0] SEL;
    logic       BUSY;
    logic       EXPIRED;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int m_owner;   // -1 when nobody owns the mux
    int m_sel;
    int m_ptr;
    int m_held;    // grant cycles seen by the current owner
    bit m_sw;      // dead cycle pending
    bit m_exp;

    mux81_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .GNT(GNT),
        .SEL(SEL), .BUSY(BUSY), .EXPIRED(EXPIRED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_sw = 0; m_exp = 0;
    endtask

    task automatic model_tick(input logic [7:0] r);
        logic [7:0] mine;
        bit found;
        m_exp = 0;
        if (m_sw) begin
            m_sw = 0;
        end else if (m_owner < 0) begin
            if (r != 8'h00) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && r[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        found = 1;
                    end
                end
                m_sel  = m_owner;
                m_held = 1;
            end
        end else begin
            mine = 8'd1 << m_owner;
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_sw = 1;
            end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && (r & ~mine) != 8'h00) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_sw = 1; m_exp = 1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end
    endtask

    // Drive REQ, take one clock edge, then compare all outputs with the model.
    task automatic step(input logic [7:0] r);
        logic [7:0] eg;
        REQ = r;
        @(posedge CLK);
        model_tick(r);
        #1;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
        chk("gnt", 32'(GNT), 32'(eg));
        chk("sel", 32'(SEL), 32'(m_sel));
        chk("busy", 32'(BUSY), 32'(m_owner >= 0));
        chk("expired", 32'(EXPIRED), 32'(m_exp));
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_sel", 32'(SEL), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_exp", 32'(EXPIRED), 32'h0);
        model_reset();
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    int         order[$];
    int         gaps[$];
    int         zrun;
    int         exp_ord[4] = '{2, 5, 7, 2};
    int         cnt3, cnt6, cnt_exp, exp_at, first_new, cnt10;
    logic [7:0] r;
    logic [7:0] prev_gnt;

    initial begin
        // Reset held with every requester active
        REQ   = 8'hFF;
        RST_N = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_gnt_ff", 32'(GNT), 32'h0);
        chk("rst_sel_ff", 32'(SEL), 32'h0);
        chk("rst_busy_ff", 32'(BUSY), 32'h0);
        RST_N = 1'b1;
        step(8'hFF);
        chk("rst_first_gnt", 32'(GNT), 32'h01);
        chk("rst_first_sel", 32'(SEL), 32'h0);

        // Round-robin order with owners releasing after three grant cycles
        do_reset();
        zrun = 0;
        prev_gnt = 8'h00;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            r = 8'hA4;
            if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
            step(r);
            if (GNT != 8'h00 && prev_gnt == 8'h00) begin
                if (order.size() > 0) gaps.push_back(zrun);
                order.push_back(int'(SEL));
                zrun = 0;
            end else if (GNT == 8'h00) begin
                zrun++;
            end
            prev_gnt = GNT;
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", 32'(order[i]), 32'(exp_ord[i]));
        for (int i = 0; i < gaps.size(); i++) chk("rr_gap", 32'(gaps[i]), 32'd2);

        // Hold limit: owner 3 is revoked after MAX_HOLD cycles in favour of 6
        do_reset();
        cnt3 = 0; cnt6 = 0; cnt_exp = 0; exp_at = -1; first_new = 99;
        for (int c = 1; c <= 10; c++) begin
            step((c == 1) ? 8'h08 : 8'h48);
            if (GNT == 8'h08) cnt3++;
            if (GNT == 8'h40) cnt6++;
            if (EXPIRED) begin cnt_exp++; exp_at = c; end
            if (GNT != 8'h00 && GNT != 8'h08 && first_new == 99) first_new = int'(SEL);
        end
        chk("hold_cycles", 32'(cnt3), 32'd4);
        chk("hold_expired_cnt", 32'(cnt_exp), 32'd1);
        chk("hold_expired_at", 32'(exp_at), 32'd5);
        chk("hold_next_sel", 32'(first_new), 32'd6);
        chk("hold_next_cycles", 32'(cnt6), 32'd4);

        // Sole requester keeps the grant indefinitely
        do_reset();
        cnt10 = 0; cnt_exp = 0;
        for (int c = 0; c < 100; c++) begin
            step(8'h10);
            if (GNT == 8'h10) cnt10++;
            if (EXPIRED) cnt_exp++;
        end
        chk("sole_gnt_cycles", 32'(cnt10), 32'd100);
        chk("sole_expired", 32'(cnt_exp), 32'd0);

        // Pointer wrap from owner 7 back to requester 0
        do_reset();
        repeat (3) step(8'h80);
        chk("wrap_owner7", 32'(GNT), 32'h80);
        step(8'h01);
        step(8'h81);
        step(8'h81);
        chk("wrap_gnt", 32'(GNT), 32'h01);
        chk("wrap_sel", 32'(SEL), 32'h0);
        // Owner 0 leaves (pointer moves to 1), then 7 is granted
        repeat (4) step(8'h80);
        chk("pre_rst_gnt", 32'(GNT), 32'h80);
        // Asynchronous reset in mid-grant, away from any clock edge
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(GNT), 32'h0);
        chk("mid_rst_sel", 32'(SEL), 32'h0);
        chk("mid_rst_busy", 32'(BUSY), 32'h0);
        model_reset();
        #3;
        RST_N = 1'b1;
        step(8'h81);
        chk("ptr_after_rst", 32'(GNT), 32'h01);

        // Random traffic against the model, with occasional async resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            case ($urandom_range(0, 3))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom) & 8'($urandom);
                2:       r = (m_owner >= 0 && $urandom_range(0, 3) != 0) ? (REQ | (8'd1 << m_owner)) : 8'($urandom);
                default: r = REQ;
            endcase
            step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
